// File: rtl/cpu_pkg.sv
// Constants and types shared by the fetch controller and the next-PC sequencer.
package cpu_pkg;

    localparam int unsigned PC_W    = 9;
    localparam int unsigned INSTR_W = 12;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam pc_t    RESET_VECTOR = 9'h1FF;
    localparam instr_t NOP_INSTR    = 12'h000;

    typedef enum logic [1:0] {
        STK_NONE,
        STK_PUSH,
        STK_POP,
        STK_REPL
    } stk_op_e;

    function automatic stk_op_e stk_op(input logic push, input logic pop);
        unique case ({push, pop})
            2'b10:   return STK_PUSH;
            2'b01:   return STK_POP;
            2'b11:   return STK_REPL;
            default: return STK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bus: program-memory port plus sequencer-facing signals.
interface fetch_ctrl_if;
    import cpu_pkg::*;

    pc_t    imem_addr;
    instr_t imem_data;
    instr_t instr;
    pc_t    exec_pc;
    logic   bubble;
    pc_t    pc_next;
    logic   push;
    logic   pop;
    pc_t    stack_psh;
    pc_t    stack_pop;

    modport master (
        output imem_addr, instr, exec_pc, bubble, stack_pop,
        input  imem_data, pc_next, push, pop, stack_psh
    );

    modport slave (
        input  imem_addr, instr, exec_pc, bubble, stack_pop,
        output imem_data, pc_next, push, pop, stack_psh
    );

endinterface

// File: rtl/fetch_ctrl_ret_stack.sv
// Hardware return stack (LIFO) with overflow discard of the oldest entry.
// Sticky flags and occupancy output exist only with FETCH_CTRL_STACK_FLAGS_EN.
module ret_stack
    import cpu_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 2,
    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            push,
    input  logic            pop,
    input  logic            clr_flags,
    input  pc_t             psh_data,
    output pc_t             top,
    output logic [SP_W-1:0] sp_out,
    output logic            ovf,
    output logic            unf
);

    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] top_idx;
    pc_t             mem [STACK_DEPTH];
    logic            full;
    logic            empty;
    stk_op_e         op;

    assign op      = stk_op(push, pop);
    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign empty   = (sp == '0);
    // Top index doubles as the replace target; an empty stack points at entry 0.
    assign top_idx = empty ? '0 : sp - 1'b1;

    always_comb begin
        top = mem[0];
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (SP_W'(i) == top_idx) top = mem[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            unique case (op)
                STK_PUSH: begin
                    if (!full) begin
                        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                            if (SP_W'(i) == sp) mem[i] <= psh_data;
                        end
                        sp <= sp + 1'b1;
                    end else begin
                        for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) mem[i] <= mem[i+1];
                        mem[STACK_DEPTH-1] <= psh_data;
                    end
                end
                STK_POP: begin
                    if (!empty) sp <= sp - 1'b1;
                end
                STK_REPL: begin
                    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                        if (SP_W'(i) == top_idx) mem[i] <= psh_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_CTRL_STACK_FLAGS_EN
    logic ovf_q;
    logic unf_q;
    logic set_ovf;
    logic set_unf;

    assign set_ovf = (op == STK_PUSH) && full;
    assign set_unf = ((op == STK_POP) || (op == STK_REPL)) && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (en) begin
            // Clear first so a same-cycle set event wins.
            if (clr_flags) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            if (set_ovf) ovf_q <= 1'b1;
            if (set_unf) unf_q <= 1'b1;
        end
    end

    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign sp_out = sp;
`else
    logic unused_clr;
    assign unused_clr = clr_flags;
    assign ovf        = 1'b0;
    assign unf        = 1'b0;
    assign sp_out     = '0;
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch / program-flow controller: fetch PC, executing IR and return stack.
// Non-sequential pc_next flushes the prefetch with a NOP bubble. Optional: FETCH_CTRL_STACK_FLAGS_EN.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    fetch_ctrl_if.master                       bus,
    input  logic                               clr_flags,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_sp,
    output logic                               stack_ovf,
    output logic                               stack_unf
);

    pc_t    fpc, fpc_d;
    pc_t    epc, epc_d;
    instr_t ir, ir_d;
    logic   bub, bub_d;
    logic   is_seq;

    assign is_seq = (bus.pc_next == pc_t'(epc + 1'b1));

    always_comb begin
        fpc_d = fpc;
        epc_d = epc;
        ir_d  = ir;
        bub_d = bub;
        if (is_seq) begin
            ir_d  = bus.imem_data;
            epc_d = fpc;
            fpc_d = fpc + 1'b1;
            bub_d = 1'b0;
        end else begin
            // Redirect: discard the prefetched word and fake exec_pc so the
            // sequencer returns the target as its sequential successor.
            ir_d  = NOP_INSTR;
            epc_d = bus.pc_next - 1'b1;
            fpc_d = bus.pc_next;
            bub_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc <= RESET_VECTOR;
            epc <= RESET_VECTOR - 1'b1;
            ir  <= NOP_INSTR;
            bub <= 1'b1;
        end else if (en) begin
            fpc <= fpc_d;
            epc <= epc_d;
            ir  <= ir_d;
            bub <= bub_d;
        end
    end

    assign bus.imem_addr = fpc;
    assign bus.instr     = ir;
    assign bus.exec_pc   = epc;
    assign bus.bubble    = bub;

    ret_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .push      (bus.push),
        .pop       (bus.pop),
        .clr_flags (clr_flags),
        .psh_data  (bus.stack_psh),
        .top       (bus.stack_pop),
        .sp_out    (stack_sp),
        .ovf       (stack_ovf),
        .unf       (stack_unf)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed steps, then randomized traffic
// against a queue-based reference model.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned SP_W  = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            clr_flags;
    logic [SP_W-1:0] stack_sp;
    logic            stack_ovf;
    logic            stack_unf;

    fetch_ctrl_if bus_if ();

    fetch_ctrl #(.STACK_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus_if),
        .clr_flags (clr_flags),
        .stack_sp  (stack_sp),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    always #5 clk = ~clk;

    instr_t mem [512];
    assign bus_if.imem_data = mem[bus_if.imem_addr];

    // Reference model state
    pc_t    m_fpc, m_epc, m_e0;
    instr_t m_ir;
    logic   m_bub, m_ovf, m_unf;
    pc_t    m_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        pc_t  nxt;
        logic so, su;
        if (rst) begin
            m_fpc = RESET_VECTOR;
            m_epc = RESET_VECTOR - 9'd1;
            m_ir  = NOP_INSTR;
            m_bub = 1'b1;
            m_q.delete();
            m_e0  = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (en) begin
            nxt = m_epc + 9'd1;
            so = 1'b0;
            su = 1'b0;
            if (bus_if.pc_next == nxt) begin
                m_ir  = mem[m_fpc];
                m_epc = m_fpc;
                m_fpc = m_fpc + 9'd1;
                m_bub = 1'b0;
            end else begin
                m_ir  = NOP_INSTR;
                m_epc = bus_if.pc_next - 9'd1;
                m_fpc = bus_if.pc_next;
                m_bub = 1'b1;
            end
            if (bus_if.push && bus_if.pop) begin
                if (m_q.size() == 0) begin
                    m_e0 = bus_if.stack_psh;
                    su = 1'b1;
                end else begin
                    m_q[m_q.size()-1] = bus_if.stack_psh;
                end
            end else if (bus_if.push) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(bus_if.stack_psh);
                end else begin
                    void'(m_q.pop_front());
                    m_q.push_back(bus_if.stack_psh);
                    so = 1'b1;
                end
            end else if (bus_if.pop) begin
                if (m_q.size() > 0) begin
                    if (m_q.size() == 1) m_e0 = m_q[0];
                    void'(m_q.pop_back());
                end else begin
                    su = 1'b1;
                end
            end
            if (clr_flags) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (so) m_ovf = 1'b1;
            if (su) m_unf = 1'b1;
        end
    endtask

    task automatic check_all();
        pc_t  e_top;
        int   e_sp;
        logic e_ovf, e_unf;
        e_top = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_e0;
`ifdef FETCH_CTRL_STACK_FLAGS_EN
        e_sp  = m_q.size();
        e_ovf = m_ovf;
        e_unf = m_unf;
`else
        e_sp  = 0;
        e_ovf = 1'b0;
        e_unf = 1'b0;
`endif
        chk("imem_addr", 32'(bus_if.imem_addr), 32'(m_fpc));
        chk("instr",     32'(bus_if.instr),     32'(m_ir));
        chk("exec_pc",   32'(bus_if.exec_pc),   32'(m_epc));
        chk("bubble",    32'(bus_if.bubble),    32'(m_bub));
        chk("stack_pop", 32'(bus_if.stack_pop), 32'(e_top));
        chk("stack_sp",  32'(stack_sp),         32'(e_sp));
        chk("stack_ovf", 32'(stack_ovf),        32'(e_ovf));
        chk("stack_unf", 32'(stack_unf),        32'(e_unf));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic p_en, input pc_t p_next, input logic p_push,
                         input logic p_pop, input pc_t p_psh, input logic p_clr);
        en               = p_en;
        bus_if.pc_next   = p_next;
        bus_if.push      = p_push;
        bus_if.pop       = p_pop;
        bus_if.stack_psh = p_psh;
        clr_flags        = p_clr;
    endtask

    task automatic stk_step(input logic p_push, input logic p_pop, input pc_t p_psh, input logic p_clr);
        drive(1'b1, m_epc + 9'd1, p_push, p_pop, p_psh, p_clr);
        cycle();
    endtask

    task automatic seq_step();
        stk_step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic jump(input pc_t tgt);
        drive(1'b1, tgt, 1'b0, 1'b0, '0, 1'b0);
        cycle();
    endtask

    initial begin
        pc_t  h_fpc, h_epc;
        instr_t h_ir;
        int   r;

        for (int a = 0; a < 512; a++) mem[a] = instr_t'(a);
        m_fpc = '0; m_epc = '0; m_e0 = '0; m_ir = '0;
        m_bub = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset
        rst = 1'b1;
        drive(1'b0, 9'h055, 1'b1, 1'b1, 9'h0AA, 1'b0);
        cycle();
        cycle();
        chk("rst_addr",   32'(bus_if.imem_addr), 32'h1FF);
        chk("rst_instr",  32'(bus_if.instr),     32'h000);
        chk("rst_epc",    32'(bus_if.exec_pc),   32'h1FE);
        chk("rst_bubble", 32'(bus_if.bubble),    32'h1);
        rst = 1'b0;

        // Straight-line fetch from the reset vector, wrapping to 0
        seq_step();
        chk("first_instr", 32'(bus_if.instr),     32'h1FF);
        chk("first_addr",  32'(bus_if.imem_addr), 32'h000);
        seq_step();
        chk("second_instr", 32'(bus_if.instr),  32'h000);
        chk("second_bub",   32'(bus_if.bubble), 32'h0);

        // Branch 0x010 -> 0x040
        for (int k = 0; k < 600 && m_epc != 9'h010; k++) seq_step();
        chk("at_010", 32'(bus_if.exec_pc), 32'h010);
        jump(9'h040);
        chk("br_instr",  32'(bus_if.instr),   32'h000);
        chk("br_epc",    32'(bus_if.exec_pc), 32'h03F);
        chk("br_bubble", 32'(bus_if.bubble),  32'h1);
        seq_step();
        chk("br_tgt_instr", 32'(bus_if.instr),   32'h040);
        chk("br_tgt_epc",   32'(bus_if.exec_pc), 32'h040);

        // Skip over 0x021; back-to-back redirect
        jump(9'h020);
        seq_step();
        chk("at_020", 32'(bus_if.exec_pc), 32'h020);
        jump(9'h022);
        chk("skip_bubble", 32'(bus_if.bubble), 32'h1);
        seq_step();
        chk("skip_epc",   32'(bus_if.exec_pc), 32'h022);
        chk("skip_instr", 32'(bus_if.instr),   32'h022);

        // Stack overflow / underflow
        stk_step(1'b1, 1'b0, 9'h011, 1'b0);
        stk_step(1'b1, 1'b0, 9'h022, 1'b0);
        stk_step(1'b1, 1'b0, 9'h033, 1'b0);
        chk("ovf_top", 32'(bus_if.stack_pop), 32'h033);
`ifdef FETCH_CTRL_STACK_FLAGS_EN
        chk("ovf_flag", 32'(stack_ovf), 32'h1);
`endif
        stk_step(1'b0, 1'b1, '0, 1'b0);
        chk("pop1_top", 32'(bus_if.stack_pop), 32'h022);
        stk_step(1'b0, 1'b1, '0, 1'b0);
        chk("pop2_top", 32'(bus_if.stack_pop), 32'h022);
        stk_step(1'b0, 1'b1, '0, 1'b0);
        chk("pop3_top", 32'(bus_if.stack_pop), 32'h022);
`ifdef FETCH_CTRL_STACK_FLAGS_EN
        chk("unf_flag", 32'(stack_unf), 32'h1);
        chk("unf_sp",   32'(stack_sp),  32'h0);
`endif
        stk_step(1'b1, 1'b1, 9'h07E, 1'b0);
        chk("repl_empty_top", 32'(bus_if.stack_pop), 32'h07E);
        stk_step(1'b0, 1'b0, '0, 1'b1);

        // Hold with en=0
        h_fpc = m_fpc; h_epc = m_epc; h_ir = m_ir;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, m_epc + 9'd5, 1'b1, 1'b0, 9'h155, 1'b1);
            cycle();
        end
        chk("hold_addr",  32'(bus_if.imem_addr), 32'(h_fpc));
        chk("hold_epc",   32'(bus_if.exec_pc),   32'(h_epc));
        chk("hold_instr", 32'(bus_if.instr),     32'(h_ir));

        // Reset during a bubble with two entries stacked
        stk_step(1'b1, 1'b0, 9'h101, 1'b0);
        stk_step(1'b1, 1'b0, 9'h102, 1'b0);
        jump(9'h0C0);
        rst = 1'b1;
        drive(1'b1, 9'h0E0, 1'b1, 1'b0, 9'h103, 1'b0);
        cycle();
        rst = 1'b0;
        chk("rst2_addr",   32'(bus_if.imem_addr), 32'h1FF);
        chk("rst2_sp",     32'(stack_sp),         32'h0);
        chk("rst2_ovf",    32'(stack_ovf),        32'h0);
        chk("rst2_unf",    32'(stack_unf),        32'h0);
        chk("rst2_bubble", 32'(bus_if.bubble),    32'h1);

        // Randomized traffic
        for (int a = 0; a < 512; a++) mem[a] = instr_t'($urandom);
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            r = $urandom_range(0, 9);
            drive(($urandom_range(0, 9) != 0),
                  (r < 6) ? m_epc + 9'd1 : (r < 8) ? m_epc + 9'd2 : pc_t'($urandom),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  pc_t'($urandom),
                  ($urandom_range(0, 7) == 0));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch and program-flow controller for the mini CPU. It owns the fetch PC, the executing-instruction register and the hardware return stack, and feeds the next-PC sequencer with the executing instruction and its address. It consumes the sequencer's `pc_next`, `push` and `pop`. Any non-sequential `pc_next` (GOTO, CALL, RETLW, taken skip, PCL write) flushes the prefetched word with a NOP bubble, giving PIC-style two-cycle branches.

## Interface
- `PC_W`, 9, program-counter width.
- `INSTR_W`, 12, instruction width.
- `STACK_DEPTH`, 2, return-stack entries; legal range 1..8.
- `RESET_VECTOR`, 9'h1FF, first fetch address after reset.
- `NOP_INSTR`, 12'h000, word injected on a flush.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  advance enable; low = hold all state.
- `imem_addr`  out  PC_W  fetch address to program memory (asynchronous read).
- `imem_data`  in  INSTR_W  program-memory word at `imem_addr`.
- `instr`  out  INSTR_W  executing instruction, to decode and sequencer.
- `exec_pc`  out  PC_W  address of `instr`, to the sequencer PC input.
- `bubble`  out  1  `instr` is an injected NOP.
- `pc_next`  in  PC_W  next PC from the sequencer.
- `push`, `pop`  in  1  stack operations from the sequencer.
- `stack_psh`  in  PC_W  return address to push.
- `stack_pop`  out  PC_W  top-of-stack (combinational).
- `stack_sp`  out  $clog2(STACK_DEPTH+1)  current occupancy.
- `stack_ovf`, `stack_unf`  out  1  sticky overflow/underflow flags.
- `clr_flags`  in  1  clears both sticky flags.

## Operation
- Registers: `fpc` (drives `imem_addr`), `ir` (drives `instr`), `epc` (drives `exec_pc`), `bub`, stack array, `sp`, flags.
- Reset values: `fpc`=RESET_VECTOR, `ir`=NOP_INSTR, `epc`=RESET_VECTOR−1 (mod 2^PC_W), `bubble`=1, `sp`=0, all stack entries 0, `stack_ovf`/`stack_unf`=0. `pc_next`, `push` and `pop` are ignored while `rst`=1.
- Sequential case (`pc_next` == `epc`+1 mod 2^PC_W): `ir`←`imem_data`, `epc`←`fpc`, `fpc`←`fpc`+1 (wraps 0x1FF→0x000), `bubble`←0.
- Redirect case (any other `pc_next`): `ir`←NOP_INSTR, `epc`←`pc_next`−1, `fpc`←`pc_next`, `bubble`←1. The prefetched word is discarded.
- During the bubble cycle the sequencer sees NOP at `pc_next`−1, so it returns `pc_next` sequentially. The target instruction then loads into `ir`.
- Stack push: entry[`sp`]←`stack_psh`, `sp`++.
  - Push when full: shift entries down and discard the oldest, write the new value to the top, leave `sp` unchanged, set `stack_ovf`.
- Stack pop: `sp`−−.
  - Pop when empty: `sp` stays 0, set `stack_unf`, leave `stack_pop` showing entry[0].
- `stack_pop` = entry[`sp`−1] when `sp`>0, otherwise entry[0].
- `push` and `pop` together: overwrite the top entry with `stack_psh`, `sp` unchanged, no flag change. If `sp`=0, write entry[0] and set `stack_unf`.
- `clr_flags` and a set event in the same cycle: the set wins.

## Timing
- All state updates on the rising `clk` edge when `en`=1. `rst` overrides `en`.
- With `en`=0, every register holds and `push`/`pop`/`clr_flags` are ignored.
- Straight-line code: one instruction per enabled cycle.
- Taken branch, call, return, skip or PCL write: 2 cycles, i.e. one bubble.
- Back-to-back redirects, including a redirect computed during a bubble, are legal; each inserts one bubble.
- `rst` asserted mid-operation: the next edge loads the reset values regardless of any pending redirect or stack operation.
- Outputs are registered except `imem_addr` (equals `fpc`) and `stack_pop`.

## Configuration
- `FETCH_CTRL_STACK_FLAGS_EN` defined: `stack_ovf`, `stack_unf`, `clr_flags` and `stack_sp` are functional as described above.
- Not defined: the flag registers are not built. `stack_ovf`/`stack_unf` are tied 0, `stack_sp` is tied 0, and `clr_flags` is ignored. Stack push/pop behaviour, including overflow discard, is unchanged.

## Structure
- Shared package `cpu_pkg` holds PC_W, INSTR_W, NOP_INSTR, RESET_VECTOR and a `pc_t` typedef. These are the same constants the sequencer uses.
- One sub-module, `ret_stack`: the depth-parameterised LIFO with `sp`, top-of-stack read and the overflow/underflow flags.
- Fetch and pipeline registers live in `fetch_ctrl`.

## Test plan
- Reset then `en`=1, memory word at each address = its address → `imem_addr` 1FF, 000, 001…; `instr` NOP (`bubble`=1) for the first cycle, then 0x1FF, 0x000 in order.
- `pc_next`=0x040 while executing at `epc`=0x010 → next cycle `instr`=NOP, `epc`=0x03F, `bubble`=1; following cycle `instr`=mem[0x040], `epc`=0x040.
- Skip: `pc_next`=`epc`+2 at `epc`=0x020 → one bubble, then `epc`=0x022; mem[0x021] never appears on `instr`.
- Two pushes (0x011, 0x022), a third push (0x033), then three pops → `stack_ovf`=1 after the third push; pops return 0x033, 0x022, then 0x022 with `stack_unf`=1 and `sp`=0.
- `en`=0 for 3 cycles with `push`=1 and a redirecting `pc_next` → `imem_addr`, `instr`, `epc`, `sp` unchanged.
- `rst` pulsed during a bubble with `sp`=2 → next cycle `imem_addr`=0x1FF, `sp`=0, both flags 0, `bubble`=1.
